// File: rtl/sigma_mem_arb2.sv
// rtl/sigma_mem_arb2.sv - two-master round-robin arbiter for the sigma shared memory port
//
// Purpose: arbitrates two req/ack/resp masters onto one slave port with zero
// added latency. Reads complete in order; a small ID FIFO records which master
// issued each accepted read so the response can be routed back.
//
// Ports:
//   clk_i, arst_i            clock, asynchronous active-high reset
//   mX_req/we/addr/be/wdata  master X request fields (X = 0 CPU, 1 UART/DMA)
//   mX_ack_o                 request accepted this cycle
//   mX_resp_o, mX_rdata_o    read data valid / data (data forced 0 when not valid)
//   s_req/we/addr/be/wdata   slave request fields (mux of the granted master)
//   s_ack_i                  slave accepted the request
//   s_resp_i, s_rdata_i      slave read response
//   err_o                    sticky: response arrived with no outstanding read
module sigma_mem_arb2 #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [AW-1:0]     m0_addr_i,
  input  logic [DW/8-1:0]   m0_be_i,
  input  logic [DW-1:0]     m0_wdata_i,
  output logic              m0_ack_o,
  output logic              m0_resp_o,
  output logic [DW-1:0]     m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [AW-1:0]     m1_addr_i,
  input  logic [DW/8-1:0]   m1_be_i,
  input  logic [DW-1:0]     m1_wdata_i,
  output logic              m1_ack_o,
  output logic              m1_resp_o,
  output logic [DW-1:0]     m1_rdata_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_addr_o,
  output logic [DW/8-1:0]   s_be_o,
  output logic [DW-1:0]     s_wdata_o,
  input  logic              s_ack_i,
  input  logic              s_resp_i,
  input  logic [DW-1:0]     s_rdata_i,
  output logic              err_o
);

  localparam int PW = $clog2(RD_DEPTH);

  logic                ptr;       // 0: m0 wins a tie, 1: m1 wins a tie
  logic                locked;
  logic                lock_id;
  logic                grant;
  logic                g_req;
  logic                rd_block;
  logic                xfer;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                head_id;
  logic [RD_DEPTH-1:0] id_mem;
  logic [PW:0]         wr_ptr;
  logic [PW:0]         rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_id = id_mem[rd_ptr[PW-1:0]];

  always_comb begin
    grant = 1'b0;
    if (locked)
      grant = lock_id;
    else if (m0_req_i && m1_req_i)
      grant = ptr;
    else if (m1_req_i)
      grant = 1'b1;
  end

  always_comb begin
    g_req     = grant ? m1_req_i   : m0_req_i;
    s_we_o    = grant ? m1_we_i    : m0_we_i;
    s_addr_o  = grant ? m1_addr_i  : m0_addr_i;
    s_be_o    = grant ? m1_be_i    : m0_be_i;
    s_wdata_o = grant ? m1_wdata_i : m0_wdata_i;
  end

  // Full FIFO is judged on registered state only, so a same-cycle pop does
  // not let a read through; writes never need a FIFO slot.
  assign rd_block = ~s_we_o & full;
  assign s_req_o  = g_req & ~rd_block;
  assign xfer     = s_req_o & s_ack_i;
  assign m0_ack_o = xfer & ~grant;
  assign m1_ack_o = xfer & grant;

  assign push = xfer & ~s_we_o;
  assign pop  = s_resp_i & ~empty;

  assign m0_resp_o  = pop & ~head_id;
  assign m1_resp_o  = pop & head_id;
  assign m0_rdata_o = m0_resp_o ? s_rdata_i : '0;
  assign m1_rdata_o = m1_resp_o ? s_rdata_i : '0;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr     <= 1'b0;
      locked  <= 1'b0;
      lock_id <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      id_mem  <= '0;
      err_o   <= 1'b0;
    end else begin
      // Hold the grant across a stalled request; a transfer always releases.
      if (xfer) begin
        locked <= 1'b0;
        ptr    <= ~grant;
      end else if (s_req_o) begin
        locked  <= 1'b1;
        lock_id <= grant;
      end
      if (push) begin
        id_mem[wr_ptr[PW-1:0]] <= grant;
        wr_ptr                 <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (s_resp_i && empty)
        err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sigma_mem_arb2.sv
// tb/tb_sigma_mem_arb2.sv - scoreboard bench for sigma_mem_arb2
module tb_sigma_mem_arb2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          arst_i;
  logic          m0_req_i, m1_req_i, m0_we_i, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [BW-1:0] m0_be_i, m1_be_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic          m0_ack_o, m1_ack_o, m0_resp_o, m1_resp_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          s_req_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [BW-1:0] s_be_o;
  logic [DW-1:0] s_wdata_o;
  logic          s_ack_i, s_resp_i;
  logic [DW-1:0] s_rdata_i;
  logic          err_o;

  always #5 clk = ~clk;

  sigma_mem_arb2 #(.AW(AW), .DW(DW), .RD_DEPTH(DEPTH)) dut (
    .clk_i(clk), .arst_i(arst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_be_i(m0_be_i),
    .m0_wdata_i(m0_wdata_i), .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_i(s_rdata_i),
    .err_o(err_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  // Reference model: outstanding read owners in issue order, tie-break
  // favourite, and the master currently holding a stalled grant.
  int r_ids[$];
  int r_fav;
  bit r_locked;
  int r_lock_id;
  bit r_err;

  // Master request registers: held until the model says they were accepted.
  bit            p_req [2];
  bit            p_we  [2];
  logic [AW-1:0] p_addr[2];
  logic [BW-1:0] p_be  [2];
  logic [DW-1:0] p_wd  [2];
  bit            sack, sresp;
  logic [DW-1:0] srdata;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic new_req(input int m, input bit we, input logic [AW-1:0] addr);
    p_req[m]  = 1'b1;
    p_we[m]   = we;
    p_addr[m] = addr;
    p_be[m]   = BW'($urandom);
    p_wd[m]   = DW'($urandom);
  endtask

  task automatic idle();
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
    sack     = 1'b0;
    sresp    = 1'b0;
  endtask

  task automatic drive();
    m0_req_i = p_req[0]; m0_we_i = p_we[0]; m0_addr_i = p_addr[0];
    m0_be_i  = p_be[0];  m0_wdata_i = p_wd[0];
    m1_req_i = p_req[1]; m1_we_i = p_we[1]; m1_addr_i = p_addr[1];
    m1_be_i  = p_be[1];  m1_wdata_i = p_wd[1];
    s_ack_i  = sack; s_resp_i = sresp; s_rdata_i = srdata;
  endtask

  // One bus cycle: drive, predict and compare at the falling edge, then
  // advance the model at the rising edge.
  task automatic cycle();
    int g;
    bit sreq, xfer, have;
    drive();
    @(negedge clk);
    if (r_locked)                g = r_lock_id;
    else if (p_req[0] && p_req[1]) g = r_fav;
    else if (p_req[1])           g = 1;
    else                         g = 0;
    sreq = p_req[g] && !(!p_we[g] && r_ids.size() == DEPTH);
    xfer = sreq && sack;
    have = r_ids.size() > 0;
    chk("s_req", s_req_o, sreq);
    if (sreq)
      chk("s_fields", {s_we_o, s_addr_o, s_be_o, s_wdata_o},
          {p_we[g], p_addr[g], p_be[g], p_wd[g]});
    chk("m0_ack", m0_ack_o, xfer && g == 0);
    chk("m1_ack", m1_ack_o, xfer && g == 1);
    chk("err", err_o, r_err);
    if (sresp && have) begin
      exp_t e;
      e.id   = r_ids[0];
      e.data = srdata;
      sb.push_back(e);
    end
    @(posedge clk);
    if (sresp && !have) r_err = 1'b1;
    if (sresp && have) void'(r_ids.pop_front());
    if (xfer && !p_we[g]) r_ids.push_back(g);
    if (xfer) begin
      r_locked = 1'b0;
      r_fav    = 1 - g;
      p_req[g] = 1'b0;
    end else if (sreq) begin
      r_locked  = 1'b1;
      r_lock_id = g;
    end
    #1;
  endtask

  task automatic do_reset();
    arst_i = 1'b1;
    idle();
    drive();
    r_ids.delete();
    r_fav    = 0;
    r_locked = 1'b0;
    r_err    = 1'b0;
    @(negedge clk);
    chk("rst_err", err_o, 1'b0);
    chk("rst_acks", {m0_ack_o, m1_ack_o, s_req_o}, 3'b000);
    chk("rst_resp", {m0_resp_o, m1_resp_o, m0_rdata_o, m1_rdata_o}, '0);
    @(posedge clk);
    #1;
    arst_i = 1'b0;
  endtask

  // Response monitor: every cycle, the expected response (if any) must be
  // on exactly the right master with the slave's data; otherwise silence.
  always begin
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.id == 0) begin
        chk("resp_sel", {m0_resp_o, m1_resp_o}, 2'b10);
        chk("rdata0", m0_rdata_o, e.data);
        chk("rdata_idle1", m1_rdata_o, '0);
      end else begin
        chk("resp_sel", {m0_resp_o, m1_resp_o}, 2'b01);
        chk("rdata1", m1_rdata_o, e.data);
        chk("rdata_idle0", m0_rdata_o, '0);
      end
    end else begin
      chk("no_resp", {m0_resp_o, m1_resp_o, m0_rdata_o, m1_rdata_o}, '0);
    end
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      p_req[m] = 1'b0; p_we[m] = 1'b0; p_addr[m] = '0; p_be[m] = '0; p_wd[m] = '0;
    end
    srdata = '0;
    idle();
    drive();
    do_reset();

    // Single m0 read, response two cycles after acceptance.
    new_req(0, 1'b0, 32'h100);
    sack = 1'b1;
    cycle();
    sack = 1'b0;
    cycle();
    sresp = 1'b1; srdata = 32'hDEADBEEF;
    cycle();
    sresp = 1'b0;
    cycle();

    // Both masters always requesting, slave always accepting.
    do_reset();
    sack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int m = 0; m < 2; m++)
        if (!p_req[m]) new_req(m, 1'b1, AW'(32'h200 + i * 16 + m * 4));
      cycle();
    end
    idle();

    // m1 stalled three cycles while m0 waits, then m0.
    do_reset();
    new_req(1, 1'b1, 32'h300);
    cycle();
    new_req(0, 1'b1, 32'h400);
    cycle();
    cycle();
    sack = 1'b1;
    cycle();
    cycle();
    idle();

    // Fill the ID FIFO with m0 reads; 5th read blocks, a write passes.
    do_reset();
    sack = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      new_req(0, 1'b0, AW'(i * 4));
      cycle();
    end
    new_req(0, 1'b0, 32'h40);
    new_req(1, 1'b1, 32'h80);
    cycle();
    cycle();
    sresp = 1'b1; srdata = DW'($urandom);
    cycle();
    sresp = 1'b0;
    cycle();
    sack = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sresp = 1'b1; srdata = DW'($urandom);
      cycle();
    end
    idle();

    // Interleaved reads m0, m1, m0 with responses 1, 2, 3.
    do_reset();
    sack = 1'b1;
    new_req(0, 1'b0, 32'h10); cycle();
    new_req(1, 1'b0, 32'h20); cycle();
    new_req(0, 1'b0, 32'h30); cycle();
    sack = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      sresp = 1'b1; srdata = DW'(i);
      cycle();
    end
    idle();
    cycle();

    // Randomised traffic with a mid-run reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++)
        if (!p_req[m] && $urandom_range(0, 3) != 0)
          new_req(m, 1'($urandom_range(0, 1)), AW'($urandom));
      sack   = ($urandom_range(0, 3) != 0);
      sresp  = (r_ids.size() > 0) && ($urandom_range(0, 2) == 0);
      srdata = DW'($urandom);
      cycle();
      if (i == 1500) do_reset();
    end
    idle();

    // Spurious response: sticky error, no routed response, cleared by reset.
    sresp = 1'b1; srdata = 32'h5A5A5A5A;
    for (int i = 0; i < DEPTH; i++) cycle();
    sresp = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    do_reset();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
